// File: rtl/high_low_rounds_pkg.sv
// Shared brainwars codes (font glyphs, keypad codes, game id) plus high/low game types.
// No timing of its own; macros are guarded so any file may rely on them.
// No flow control; definitions only.
`ifndef BRAINWARS_DEFS
`define BRAINWARS_DEFS
`define FONT_0 8'h30
`define FONT_1 8'h31
`define FONT_2 8'h32
`define FONT_3 8'h33
`define FONT_4 8'h34
`define FONT_5 8'h35
`define FONT_6 8'h36
`define FONT_7 8'h37
`define FONT_8 8'h38
`define FONT_9 8'h39
`define HL_KEY_HIGH 4'hA
`define HL_KEY_LOW  4'hB
`define HL_GAME_ID  3'b010
`endif

package high_low_rounds_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAW,
        ST_SHOW,
        ST_FEEDBACK,
        ST_DONE
    } state_t;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [7:0] font_of(input logic [3:0] d);
        case (d)
            4'd0:    return `FONT_0;
            4'd1:    return `FONT_1;
            4'd2:    return `FONT_2;
            4'd3:    return `FONT_3;
            4'd4:    return `FONT_4;
            4'd5:    return `FONT_5;
            4'd6:    return `FONT_6;
            4'd7:    return `FONT_7;
            4'd8:    return `FONT_8;
            4'd9:    return `FONT_9;
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/high_low_rounds_rand.sv
// rand_bcd_gen: free-running 16-bit Galois LFSR folded into DIGITS BCD digits.
// Digits are combinational from the LFSR register; LFSR advances every tick.
// No backpressure; consumers sample whenever they need a value.
module rand_bcd_gen
    import high_low_rounds_pkg::*;
#(
    parameter int          DIGITS = 2,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic                clk_100,
    input  logic                rst_n,
    output logic [4*DIGITS-1:0] digits
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    always_comb begin
        digits = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digits[4*i +: 4] = (lfsr_q[4*i +: 4] > 4'd9) ? lfsr_q[4*i +: 4] - 4'd10
                                                          : lfsr_q[4*i +: 4];
        end
    end

endmodule

// File: rtl/high_low_rounds.sv
// Fixed-length high/low guessing match with BCD score and registered 128-bit font frame.
// Press edge to point/miss is 2 ticks (+1 per rejected redraw); frame lags state by 1 tick.
// No backpressure; presses outside SHOW are dropped and held keys never re-trigger.
module high_low_rounds
    import high_low_rounds_pkg::*;
#(
    parameter int          DIGITS        = 2,
    parameter int          ROUNDS        = 10,
    parameter int          TIMEOUT_TICKS = 300,
    parameter int          FB_TICKS      = 25,
    parameter logic [2:0]  GAME_ID       = `HL_GAME_ID,
    parameter logic [3:0]  KEY_HIGH      = `HL_KEY_HIGH,
    parameter logic [3:0]  KEY_LOW       = `HL_KEY_LOW,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic         clk_100,
    input  logic         rst_n,
    input  logic [2:0]   game_en,
    input  logic [3:0]   key,
    input  logic         pressed,
    output logic [127:0] data_output,
    output logic         point,
    output logic         miss,
    output logic [7:0]   score,
    output logic         done
);

    localparam int          NW        = 4 * DIGITS;
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_TICKS - 1);
    localparam logic [15:0] FB_LAST   = 16'(FB_TICKS - 1);
    localparam logic [6:0]  ROUND_MAX = 7'(ROUNDS);

    state_t        state_q, state_nx;
    logic [NW-1:0] cur_q, rnd_dat;
    logic [15:0]   timer_q;
    logic [6:0]    round_q;
    logic          pressed_q, guess_pend_q, guess_high_q;
    logic          en, guess_vld, timeout, fresh, judge, hit;
    logic [127:0]  frame;

    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        if (v == 8'h99) return v;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    rand_bcd_gen #(
        .DIGITS (DIGITS),
        .SEED   (SEED)
    ) u_rand (
        .clk_100 (clk_100),
        .rst_n   (rst_n),
        .digits  (rnd_dat)
    );

    assign en        = (game_en == GAME_ID);
    assign guess_vld = (state_q == ST_SHOW) && pressed && !pressed_q
                       && ((key == KEY_HIGH) || (key == KEY_LOW));
    assign timeout   = (state_q == ST_SHOW) && (timer_q == TO_LAST);
    assign fresh     = (rnd_dat != cur_q);
    assign done      = (state_q == ST_DONE);

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            ST_IDLE:     state_nx = ST_DRAW;
            ST_DRAW:     if (fresh) state_nx = guess_pend_q ? ST_FEEDBACK : ST_SHOW;
            ST_SHOW: begin
                if (guess_vld)    state_nx = ST_DRAW;
                else if (timeout) state_nx = ST_FEEDBACK;
            end
            ST_FEEDBACK: if (timer_q == FB_LAST) state_nx = (round_q < ROUND_MAX) ? ST_SHOW : ST_DONE;
            ST_DONE:     state_nx = ST_DONE;
            default:     state_nx = ST_IDLE;
        endcase
        if (!en) state_nx = ST_IDLE;
    end

    // In DRAW, cur_q still holds the previous number; BCD digits <= 9 make a plain
    // unsigned compare equal to an MSD-first decimal compare.
    always_comb begin
        judge = 1'b0;
        hit   = 1'b0;
        if (en) begin
            case (state_q)
                ST_DRAW: if (fresh && guess_pend_q) begin
                    judge = 1'b1;
                    hit   = guess_high_q ? (rnd_dat > cur_q) : (rnd_dat < cur_q);
                end
                ST_SHOW: if (timeout && !guess_vld) judge = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        frame = '0;
        if (en) begin
            if (state_q != ST_FEEDBACK) begin
                for (int d = 0; d < DIGITS; d++) begin
                    frame[127-8*(7-DIGITS+d) -: 8] = font_of(cur_q[4*(DIGITS-1-d) +: 4]);
                end
            end
            frame[127-8*14 -: 8] = font_of(score[7:4]);
            frame[7:0]           = font_of(score[3:0]);
        end
    end

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            pressed_q    <= 1'b0;
            guess_pend_q <= 1'b0;
            guess_high_q <= 1'b0;
            cur_q        <= '0;
            timer_q      <= '0;
            round_q      <= '0;
            score        <= '0;
            point        <= 1'b0;
            miss         <= 1'b0;
            data_output  <= '0;
        end else begin
            pressed_q   <= pressed;
            point       <= judge && hit;
            miss        <= judge && !hit;
            data_output <= frame;
            timer_q     <= ((state_nx == state_q) && ((state_q == ST_SHOW) || (state_q == ST_FEEDBACK)))
                           ? timer_q + 16'd1 : '0;
            if (state_nx == ST_IDLE) begin
                guess_pend_q <= 1'b0;
                guess_high_q <= 1'b0;
                cur_q        <= '0;
                round_q      <= '0;
                score        <= '0;
            end else begin
                if (guess_vld) begin
                    guess_pend_q <= 1'b1;
                    guess_high_q <= (key == KEY_HIGH);
                end
                if ((state_q == ST_DRAW) && fresh) begin
                    cur_q        <= rnd_dat;
                    guess_pend_q <= 1'b0;
                end
                if (judge) begin
                    round_q <= round_q + 7'd1;
                    if (hit) score <= bcd_inc_sat(score);
                end
            end
        end
    end

endmodule

// File: tb/tb_high_low_rounds.sv
// Directed bench for high_low_rounds (DIGITS=2, ROUNDS=3); random draws are pinned by forcing.
module tb_high_low_rounds;

    logic         clk_100 = 1'b0;
    logic         rst_n;
    logic [2:0]   game_en;
    logic [3:0]   key;
    logic         pressed;
    logic [127:0] data_output;
    logic         point, miss, done;
    logic [7:0]   score;

    int checks = 0;
    int errors = 0;
    int np, nm;

    always #5 clk_100 = ~clk_100;

    high_low_rounds #(
        .DIGITS        (2),
        .ROUNDS        (3),
        .TIMEOUT_TICKS (300),
        .FB_TICKS      (25),
        .GAME_ID       (3'b010),
        .KEY_HIGH      (4'hA),
        .KEY_LOW       (4'hB),
        .SEED          (16'hACE1)
    ) dut (
        .clk_100     (clk_100),
        .rst_n       (rst_n),
        .game_en     (game_en),
        .key         (key),
        .pressed     (pressed),
        .data_output (data_output),
        .point       (point),
        .miss        (miss),
        .score       (score),
        .done        (done)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk_100);
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Glyphs are ASCII-style: digit d renders as 8'h30+d.
    function automatic logic [127:0] exp_frame(input logic [7:0] num, input logic show_num,
                                               input logic [7:0] sc);
        logic [127:0] f;
        f = '0;
        if (show_num) begin
            f[127-8*5 -: 8] = 8'h30 + {4'd0, num[7:4]};
            f[127-8*6 -: 8] = 8'h30 + {4'd0, num[3:0]};
        end
        f[127-8*14 -: 8] = 8'h30 + {4'd0, sc[7:4]};
        f[7:0]           = 8'h30 + {4'd0, sc[3:0]};
        return f;
    endfunction

    initial begin
        rst_n   = 1'b0;
        game_en = 3'b010;
        key     = 4'h0;
        pressed = 1'b0;
        force dut.rnd_dat = 8'h37;
        tick(2);
        check("rst_frame", data_output, 128'd0);
        check("rst_point", 128'(point), 128'd0);
        check("rst_miss",  128'(miss),  128'd0);
        check("rst_score", 128'(score), 128'd0);
        check("rst_done",  128'(done),  128'd0);

        // Match 1: correct HIGH, wrong LOW after one rejected redraw, timeout.
        rst_n = 1'b1;
        tick(1);
        check("frame_after_release", data_output, exp_frame(8'h00, 1'b1, 8'h00));
        tick(2);
        check("frame_cur37", data_output, exp_frame(8'h37, 1'b1, 8'h00));
        force dut.rnd_dat = 8'h52;
        key = 4'hA; pressed = 1'b1;
        tick(1);
        check("high_no_pulse_1tick", 128'(point), 128'd0);
        tick(1);
        check("high_point_2ticks", 128'(point), 128'd1);
        check("high_no_miss", 128'(miss), 128'd0);
        check("high_score", 128'(score), 128'h01);
        tick(1);
        check("point_one_tick", 128'(point), 128'd0);
        check("feedback_blank", data_output, exp_frame(8'h00, 1'b0, 8'h01));
        pressed = 1'b0; key = 4'h0;
        tick(25);
        check("frame_cur52", data_output, exp_frame(8'h52, 1'b1, 8'h01));

        key = 4'hB; pressed = 1'b1;
        tick(2);
        check("reject_delays_pulse", 128'({point, miss}), 128'd0);
        force dut.rnd_dat = 8'h61;
        tick(1);
        check("low_miss", 128'(miss), 128'd1);
        check("low_no_point", 128'(point), 128'd0);
        check("low_score_kept", 128'(score), 128'h01);
        pressed = 1'b0; key = 4'h0;

        tick(30);
        key = 4'h3; pressed = 1'b1;
        tick(3);
        pressed = 1'b0; key = 4'h0;
        tick(291);
        check("timeout_not_early", 128'(miss), 128'd0);
        tick(1);
        check("timeout_miss", 128'(miss), 128'd1);
        check("timeout_no_point", 128'(point), 128'd0);
        check("timeout_score", 128'(score), 128'h01);
        tick(24);
        check("done_not_early", 128'(done), 128'd0);
        tick(1);
        check("done_after_3_rounds", 128'(done), 128'd1);
        tick(1);
        check("done_frame_no_redraw", data_output, exp_frame(8'h61, 1'b1, 8'h01));

        // Match 2: all correct, first guess key held for 200 ticks.
        game_en = 3'b000;
        tick(1);
        check("disabled_frame", data_output, 128'd0);
        check("disabled_score", 128'(score), 128'd0);
        check("disabled_done", 128'(done), 128'd0);
        game_en = 3'b010;
        force dut.rnd_dat = 8'h10;
        tick(2);
        force dut.rnd_dat = 8'h20;
        key = 4'hA; pressed = 1'b1;
        np = 0; nm = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (point) np++;
            if (miss) nm++;
        end
        check("held_points", 128'(np), 128'd1);
        check("held_misses", 128'(nm), 128'd0);
        check("held_score", 128'(score), 128'h01);
        pressed = 1'b0; key = 4'h0;
        tick(1);
        force dut.rnd_dat = 8'h30;
        key = 4'hA; pressed = 1'b1;
        tick(2);
        check("m2_r2_point", 128'(point), 128'd1);
        pressed = 1'b0; key = 4'h0;
        tick(26);
        force dut.rnd_dat = 8'h05;
        key = 4'hB; pressed = 1'b1;
        tick(2);
        check("m2_r3_low_point", 128'(point), 128'd1);
        check("m2_score3", 128'(score), 128'h03);
        pressed = 1'b0; key = 4'h0;
        tick(25);
        check("m2_done", 128'(done), 128'd1);
        check("m2_final_score", 128'(score), 128'h03);

        // Match 3: abort in FEEDBACK, then re-enable.
        game_en = 3'b000;
        tick(1);
        game_en = 3'b010;
        force dut.rnd_dat = 8'h10;
        tick(2);
        force dut.rnd_dat = 8'h45;
        key = 4'hA; pressed = 1'b1;
        tick(2);
        check("m3_point", 128'(point), 128'd1);
        check("m3_score", 128'(score), 128'h01);
        pressed = 1'b0; key = 4'h0;
        tick(3);
        game_en = 3'b000;
        tick(1);
        check("abort_frame_zero", data_output, 128'd0);
        check("abort_score_zero", 128'(score), 128'd0);
        check("abort_no_pulse", 128'({point, miss}), 128'd0);
        game_en = 3'b010;
        tick(1);
        check("reenable_score", 128'(score), 128'd0);
        check("reenable_frame", data_output, exp_frame(8'h00, 1'b1, 8'h00));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/high_low_rounds.md
# high_low_rounds

Parametrised successor to the single-shot high/low mini-game in the brainwars main game. It plays a fixed-length match: shows a random DIGITS-wide decimal number, then asks the player to predict whether the next number is higher or lower. It times each guess, keeps a BCD score and renders number plus score into the 128-bit frame sent to ram_ctrl. It sits beside the other game blocks, selected by game_en, and feeds the shared point/score path.

## Interface
- DIGITS, 2, displayed number width in decimal digits (1..4)
- ROUNDS, 10, guesses per match (1..99)
- TIMEOUT_TICKS, 300, clk_100 ticks allowed per guess (3 s)
- FB_TICKS, 25, feedback blank time after each guess
- GAME_ID, 3'b010, game_en value that enables this block
- KEY_HIGH, 4'hA, keypad code for "higher"
- KEY_LOW, 4'hB, keypad code for "lower"
- SEED, 16'hACE1, non-zero LFSR reset value

Ports:
- clk_100  in  1  100 Hz system tick clock
- rst_n  in  1  asynchronous, active-low reset
- game_en  in  3  game select; block active only when equal to GAME_ID
- key  in  4  keypad code, valid while pressed=1
- pressed  in  1  keypad pressed level
- data_output  out  128  16 font bytes; byte p (0 = leftmost) at bits [127-8p -: 8]
- point  out  1  one-tick pulse on a correct guess
- miss  out  1  one-tick pulse on a wrong guess or timeout
- score  out  8  BCD score {tens, units}
- done  out  1  high while in DONE

## Operation
- States: IDLE, DRAW, SHOW, FEEDBACK, DONE.
- IDLE: entered on reset or whenever game_en != GAME_ID, from any state, on the next edge. Clears score, round counter, timer and the previous-number register.
- IDLE -> DRAW when game_en == GAME_ID.
- DRAW:
  - One tick per attempt. Takes a candidate of DIGITS BCD digits from rand_bcd_gen.
  - If the candidate equals the current number, it is rejected and DRAW repeats.
  - Otherwise the old number moves to prev, the candidate becomes cur, and the state goes to SHOW.
  - The first draw of a match only loads cur and does not count as a round.
- SHOW:
  - Timer counts up from 0.
  - A guess is accepted only on the rising edge of pressed (pressed=1, previous sample 0) with key == KEY_HIGH or KEY_LOW. Any other key is ignored.
  - On a valid guess, DRAW runs first. The guess is then judged on the transition out of DRAW: correct if (KEY_HIGH and cur > prev) or (KEY_LOW and cur < prev).
  - Comparison is a magnitude compare of the BCD digit vectors, MSD first.
  - Timer reaching TIMEOUT_TICKS-1 with no valid guess is judged as a miss, without a redraw.
- Judging:
  - Emits the point or miss pulse.
  - Increments the BCD score on point; score saturates at 8'h99.
  - Increments the round counter, then enters FEEDBACK.
- FEEDBACK:
  - Lasts FB_TICKS ticks, with the number field blanked.
  - Then goes to SHOW if round < ROUNDS, else DONE.
- DONE: holds until game_en changes.
- Display:
  - Number digits occupy bytes 7-DIGITS .. 6, MSD left, using `FONT_0..`FONT_9.
  - Score occupies bytes 14 (tens) and 15 (units).
  - All other bytes are 8'd0.
  - data_output is 128'd0 when game_en != GAME_ID.
- Reset values: all outputs 0; state IDLE; LFSR = SEED.

## Timing
- Everything is registered on posedge clk_100. rst_n acts immediately and asynchronously.
- Press edge to point/miss pulse: exactly 2 ticks (accept into DRAW, judge). A rejected redraw adds 1 tick per repeat.
- data_output is a registered frame and updates the tick after any display state change.
- point and miss are mutually exclusive and never last longer than 1 tick.
- A press arriving on the same tick as the timeout wins; it is judged as a guess.
- Held keys never re-trigger; a new guess needs pressed to return to 0 first.
- Presses in DRAW, FEEDBACK and DONE are ignored.
- game_en dropping mid-round aborts with no pulse. The next enable starts from score 0.

## Structure
- Shared global header supplies the FONT_* macros. Add HL_KEY_HIGH, HL_KEY_LOW and the GAME_ID code there rather than as literals.
- Sub-module rand_bcd_gen:
  - 16-bit Galois LFSR, free-running every tick.
  - Outputs DIGITS BCD digits, each taken from a 4-bit slice; values 10..15 have 10 subtracted.
- BCD score increment is a local function; no sub-module.

## Test plan
- Reset with game_en=3'b010 -> outputs all 0; after release, bytes 5-6 show two font digits, bytes 14-15 show `FONT_0 `FONT_0.
- Force cur=37; press KEY_HIGH; next draw 52 -> point pulse 2 ticks after the press edge, score=8'h01.
- Force cur=37; press KEY_LOW; next draw 52 -> miss pulse, score unchanged.
- No press for 300 ticks -> miss on tick 300, no redraw.
- Key held for 200 ticks -> exactly one judgement. KEY 4'h3 pressed -> ignored.
- Complete ROUNDS=3 with all guesses correct -> score=8'h03 and done=1. Drop game_en mid-FEEDBACK -> data_output=0 next tick, and re-enable gives score 0.
